// File: rtl/usb_asp_spi_engine.sv
// SPI master shift engine (CPOL=1, CPHA=1, MSB first) between the vendor control endpoint's
// OUT byte buffer and its IN byte buffer.
module usb_asp_spi_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] length,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [4:0] tx_addr,
  input  logic [7:0] tx_data,
  output logic       rx_we,
  output logic [4:0] rx_addr,
  output logic [7:0] rx_data,
  output logic       spi_clk,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOW,
    HIGH,
    CS_HOLD
  } state_t;

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [5:0]  idx_reg, idx_next;
  logic [5:0]  len_reg, len_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic        load_reg, load_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        rx_we_reg, rx_we_next;
  logic [4:0]  rx_addr_reg, rx_addr_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        sck_reg, sck_next;
  logic        csn_reg, csn_next;
  logic        tick_end;

  assign tick_end = (cnt_reg == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= RELOAD;
      idx_reg      <= 6'd0;
      len_reg      <= 6'd0;
      bit_reg      <= 3'd7;
      tx_shift_reg <= 8'd0;
      rx_shift_reg <= 8'd0;
      load_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rx_we_reg    <= 1'b0;
      rx_addr_reg  <= 5'd0;
      rx_data_reg  <= 8'd0;
      sck_reg      <= 1'b1;
      csn_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      len_reg      <= len_next;
      bit_reg      <= bit_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      load_reg     <= load_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      rx_we_reg    <= rx_we_next;
      rx_addr_reg  <= rx_addr_next;
      rx_data_reg  <= rx_data_next;
      sck_reg      <= sck_next;
      csn_reg      <= csn_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg - 16'd1;
    idx_next      = idx_reg;
    len_next      = len_reg;
    bit_next      = bit_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    load_next     = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    rx_we_next    = 1'b0;
    rx_addr_next  = rx_addr_reg;
    rx_data_next  = rx_data_reg;
    sck_next      = sck_reg;
    csn_next      = csn_reg;

    case (state_reg)
      IDLE: begin
        cnt_next      = RELOAD;
        tx_shift_next = 8'd0;
        if (start && !abort) begin
          if (length != 6'd0) begin
            state_next = CS_SETUP;
            len_next   = length;
            idx_next   = 6'd0;
            busy_next  = 1'b1;
            csn_next   = 1'b0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      CS_SETUP: begin
        if (tick_end) begin
          state_next = LOW;
          cnt_next   = RELOAD;
          bit_next   = 3'd7;
          sck_next   = 1'b0;
          load_next  = 1'b1;
        end
      end
      LOW: begin
        // First LOW cycle of a byte: capture the buffer word addressed by the byte index.
        if (load_reg) tx_shift_next = tx_data;
        if (tick_end) begin
          state_next    = HIGH;
          cnt_next      = RELOAD;
          sck_next      = 1'b1;
          rx_shift_next = {rx_shift_reg[6:0], spi_miso};
        end
      end
      HIGH: begin
        if (tick_end) begin
          cnt_next = RELOAD;
          if (bit_reg != 3'd0) begin
            state_next    = LOW;
            bit_next      = bit_reg - 3'd1;
            sck_next      = 1'b0;
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          end else begin
            rx_we_next   = 1'b1;
            rx_addr_next = idx_reg[4:0];
            rx_data_next = rx_shift_reg;
            idx_next     = idx_reg + 6'd1;
            if ((idx_reg + 6'd1) == len_reg) begin
              state_next = CS_HOLD;
            end else begin
              state_next = LOW;
              bit_next   = 3'd7;
              sck_next   = 1'b0;
              load_next  = 1'b1;
            end
          end
        end
      end
      CS_HOLD: begin
        if (tick_end) begin
          state_next = IDLE;
          cnt_next   = RELOAD;
          csn_next   = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = RELOAD;
      end
    endcase

    // Cancel overrides every event above; a half-assembled byte is simply dropped.
    if (abort && (state_reg != IDLE)) begin
      state_next    = IDLE;
      cnt_next      = RELOAD;
      csn_next      = 1'b1;
      sck_next      = 1'b1;
      busy_next     = 1'b0;
      done_next     = 1'b0;
      rx_we_next    = 1'b0;
      load_next     = 1'b0;
      tx_shift_next = 8'd0;
      rx_addr_next  = rx_addr_reg;
      rx_data_next  = rx_data_reg;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign tx_addr  = idx_reg[4:0];
  assign rx_we    = rx_we_reg;
  assign rx_addr  = rx_addr_reg;
  assign rx_data  = rx_data_reg;
  assign spi_clk  = sck_reg;
  assign spi_csn  = csn_reg;
  // MSB comes straight from the buffer in the load cycle so it is valid from SCK fall even at CLK_DIV=1.
  assign spi_mosi = load_reg ? tx_data[7] : tx_shift_reg[7];

endmodule

// File: tb/tb_usb_asp_spi_engine.sv
// Bench for usb_asp_spi_engine: one instance at CLK_DIV=4 (index 0), one at CLK_DIV=1 (index 1).
module tb_usb_asp_spi_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  logic       start_s[2]   = '{1'b0, 1'b0};
  logic       abort_s[2]   = '{1'b0, 1'b0};
  logic [5:0] length_s[2]  = '{6'd0, 6'd0};
  logic [7:0] tx_data_s[2];
  logic       miso_s[2];
  logic       busy_s[2], done_s[2], rx_we_s[2], sck_s[2], csn_s[2], mosi_s[2];
  logic [4:0] tx_addr_s[2], rx_addr_s[2];
  logic [7:0] rx_data_s[2];

  logic [7:0]  tx_mem[2][32];
  logic [7:0]  resp_mem[2][32];
  logic        miso_mode[2] = '{1'b0, 1'b0};
  int          sck_base[2]  = '{0, 0};

  int          done_cnt[2] = '{0, 0};
  int          done_cyc[2] = '{0, 0};
  int          rx_cnt[2]   = '{0, 0};
  logic [12:0] rx_log[2][256];
  int          csn_low[2]  = '{0, 0};
  int          busy_cnt[2] = '{0, 0};
  int          sck_tog[2]  = '{0, 0};
  int          sck_rise[2] = '{0, 0};
  logic        sck_prev[2] = '{1'b1, 1'b1};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    usb_asp_spi_engine #(.CLK_DIV(gi == 0 ? 4 : 1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start_s[gi]),
      .length  (length_s[gi]),
      .abort   (abort_s[gi]),
      .busy    (busy_s[gi]),
      .done    (done_s[gi]),
      .tx_addr (tx_addr_s[gi]),
      .tx_data (tx_data_s[gi]),
      .rx_we   (rx_we_s[gi]),
      .rx_addr (rx_addr_s[gi]),
      .rx_data (rx_data_s[gi]),
      .spi_clk (sck_s[gi]),
      .spi_csn (csn_s[gi]),
      .spi_mosi(mosi_s[gi]),
      .spi_miso(miso_s[gi])
    );
  end

  // Buffer model and SPI slave: the slave returns resp_mem bytes MSB first, advancing per SCK rise.
  always_comb begin
    logic [31:0] p;
    logic [7:0]  b;
    p = 32'd0;
    b = 8'd0;
    for (int u = 0; u < 2; u++) begin
      p = sck_rise[u] - sck_base[u];
      b = resp_mem[u][p[7:3]];
      miso_s[u]    = miso_mode[u] ? b[~p[2:0]] : mosi_s[u];
      tx_data_s[u] = tx_mem[u][tx_addr_s[u]];
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (done_s[u]) begin
        done_cnt[u]++;
        done_cyc[u] = cyc;
      end
      if (rx_we_s[u]) begin
        if (rx_cnt[u] < 256) rx_log[u][rx_cnt[u]] = {rx_addr_s[u], rx_data_s[u]};
        rx_cnt[u]++;
      end
      if (!csn_s[u]) csn_low[u]++;
      if (busy_s[u]) busy_cnt[u]++;
      if (sck_s[u] != sck_prev[u]) sck_tog[u]++;
      if (sck_s[u] && !sck_prev[u]) sck_rise[u]++;
      sck_prev[u] = sck_s[u];
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Full transfer against the reference rules: latency, bytes, SCK count, CS window.
  task automatic run_xfer(input string name, input int u, input int n, input bit mode,
                          input int extra_at);
    int d, lat, csn_win, t0, b_rx, b_done, b_csn, b_tog, w;
    bit seen;
    logic [12:0] exp_e;
    d = (u == 0) ? 4 : 1;
    lat = 1 + d * (2 + 16 * n);
    csn_win = d * (2 + 16 * n);
    miso_mode[u] = mode;
    step;
    b_rx = rx_cnt[u]; b_done = done_cnt[u]; b_csn = csn_low[u]; b_tog = sck_tog[u];
    sck_base[u] = sck_rise[u];
    start_s[u] = 1'b1;
    length_s[u] = 6'(n);
    t0 = cyc;
    step;
    start_s[u] = 1'b0;
    length_s[u] = 6'($urandom_range(0, 63));
    w = 1;
    seen = 0;
    while (!seen && w < lat + 50) begin
      if (extra_at != 0 && w == extra_at) begin
        start_s[u] = 1'b1;
        length_s[u] = 6'd5;
      end else begin
        start_s[u] = 1'b0;
      end
      step;
      w++;
      if (done_cnt[u] != b_done) seen = 1;
    end
    start_s[u] = 1'b0;
    checks++;
    if (!seen || (done_cyc[u] - t0) != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, done_cyc[u] - t0, seen, lat);
    end
    checks++;
    if (rx_cnt[u] - b_rx != n) begin
      errors++;
      $display("FAIL %s rx_count: got %0d want %0d", name, rx_cnt[u] - b_rx, n);
    end
    for (int i = 0; i < n; i++) begin
      exp_e = {5'(i), mode ? resp_mem[u][i] : tx_mem[u][i]};
      checks++;
      if (rx_log[u][b_rx + i] !== exp_e) begin
        errors++;
        $display("FAIL %s rx_byte%0d: got addr=%0d data=%02h want addr=%0d data=%02h", name, i,
                 rx_log[u][b_rx + i][12:8], rx_log[u][b_rx + i][7:0], exp_e[12:8], exp_e[7:0]);
      end
    end
    checks++;
    if (sck_rise[u] - sck_base[u] != 8 * n || sck_tog[u] - b_tog != 16 * n) begin
      errors++;
      $display("FAIL %s sck_edges: got rises=%0d toggles=%0d want %0d/%0d", name,
               sck_rise[u] - sck_base[u], sck_tog[u] - b_tog, 8 * n, 16 * n);
    end
    checks++;
    if (csn_low[u] - b_csn != csn_win) begin
      errors++;
      $display("FAIL %s csn_window: got %0d want %0d", name, csn_low[u] - b_csn, csn_win);
    end
    repeat (4) step;
    checks++;
    if (done_cnt[u] - b_done != 1 || busy_s[u] !== 1'b0 || csn_s[u] !== 1'b1 || sck_s[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: got dones=%0d busy=%b csn=%b sck=%b want 1/0/1/1", name,
               done_cnt[u] - b_done, busy_s[u], csn_s[u], sck_s[u]);
    end
    $display("xfer %s: unit=%0d len=%0d mode=%0d latency=%0d", name, u, n, mode, done_cyc[u] - t0);
  endtask

  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({busy_s[u], done_s[u], rx_we_s[u], tx_addr_s[u], rx_addr_s[u], rx_data_s[u],
           sck_s[u], csn_s[u], mosi_s[u]} !== {3'b000, 5'd0, 5'd0, 8'd0, 3'b110}) begin
        errors++;
        $display("FAIL reset_values u%0d: got busy=%b done=%b we=%b sck=%b csn=%b mosi=%b", u,
                 busy_s[u], done_s[u], rx_we_s[u], sck_s[u], csn_s[u], mosi_s[u]);
      end
    end
    $display("reset: values checked");
  endtask

  task automatic test_single_loopback;
    tx_mem[0][0] = 8'hA5;
    run_xfer("single_loop", 0, 1, 1'b0, 0);
  endtask

  task automatic test_three_bytes;
    tx_mem[0][0] = 8'h01; tx_mem[0][1] = 8'h80; tx_mem[0][2] = 8'hFF;
    resp_mem[0][0] = 8'h3C; resp_mem[0][1] = 8'hC3; resp_mem[0][2] = 8'h00;
    run_xfer("three_bytes", 0, 3, 1'b1, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        tx_mem[0][i] = 8'($urandom);
        resp_mem[0][i] = 8'($urandom);
      end
      run_xfer("random", 0, $urandom_range(1, 8), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_max_fast;
    for (int i = 0; i < 32; i++) begin
      tx_mem[1][i] = 8'($urandom);
      resp_mem[1][i] = 8'($urandom);
    end
    run_xfer("max_fast", 1, 32, 1'b1, 0);
  endtask

  task automatic test_zero_length;
    int b_done, b_csn, b_tog, b_busy, t0;
    step;
    b_done = done_cnt[0]; b_csn = csn_low[0]; b_tog = sck_tog[0]; b_busy = busy_cnt[0];
    start_s[0] = 1'b1;
    length_s[0] = 6'd0;
    t0 = cyc;
    step;
    start_s[0] = 1'b0;
    repeat (10) step;
    checks++;
    if (done_cnt[0] - b_done != 1 || done_cyc[0] - t0 != 1) begin
      errors++;
      $display("FAIL zero_len_done: got dones=%0d at +%0d want 1 at +1", done_cnt[0] - b_done,
               done_cyc[0] - t0);
    end
    checks++;
    if (csn_low[0] != b_csn || sck_tog[0] != b_tog || busy_cnt[0] != b_busy) begin
      errors++;
      $display("FAIL zero_len_quiet: got csn_low=%0d sck_tog=%0d busy=%0d want 0/0/0",
               csn_low[0] - b_csn, sck_tog[0] - b_tog, busy_cnt[0] - b_busy);
    end
    $display("zero_len: done after %0d cycle(s)", done_cyc[0] - t0);
  endtask

  task automatic test_abort;
    int b_rx, b_done, sb, w;
    for (int i = 0; i < 32; i++) tx_mem[0][i] = 8'($urandom);
    miso_mode[0] = 1'b0;
    step;
    b_rx = rx_cnt[0]; b_done = done_cnt[0]; sb = sck_rise[0];
    sck_base[0] = sck_rise[0];
    start_s[0] = 1'b1;
    length_s[0] = 6'd4;
    step;
    start_s[0] = 1'b0;
    w = 0;
    while (!((sck_rise[0] - sb) == 12 && sck_s[0] == 1'b0) && w < 400) begin
      step;
      w++;
    end
    checks++;
    if (w >= 400) begin
      errors++;
      $display("FAIL abort_reach_bit3: got rises=%0d want 12 within 400 cycles", sck_rise[0] - sb);
    end
    abort_s[0] = 1'b1;
    step;
    abort_s[0] = 1'b0;
    checks++;
    if (csn_s[0] !== 1'b1 || sck_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got csn=%b sck=%b busy=%b want 1/1/0", csn_s[0], sck_s[0],
               busy_s[0]);
    end
    repeat (100) step;
    checks++;
    if (done_cnt[0] != b_done || rx_cnt[0] - b_rx != 1) begin
      errors++;
      $display("FAIL abort_no_done: got dones=%0d rx=%0d want 0/1", done_cnt[0] - b_done,
               rx_cnt[0] - b_rx);
    end
    checks++;
    if (rx_log[0][b_rx] !== {5'd0, tx_mem[0][0]}) begin
      errors++;
      $display("FAIL abort_byte0: got %h want %h", rx_log[0][b_rx], {5'd0, tx_mem[0][0]});
    end
    $display("abort: rx after abort=%0d", rx_cnt[0] - b_rx);
  endtask

  task automatic test_abort_start_idle;
    int b_done, b_busy, b_csn;
    step;
    b_done = done_cnt[0]; b_busy = busy_cnt[0]; b_csn = csn_low[0];
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    length_s[0] = 6'd2;
    step;
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    repeat (20) step;
    checks++;
    if (done_cnt[0] != b_done || busy_cnt[0] != b_busy || csn_low[0] != b_csn) begin
      errors++;
      $display("FAIL abort_start_idle: got dones=%0d busy=%0d csn_low=%0d want 0/0/0",
               done_cnt[0] - b_done, busy_cnt[0] - b_busy, csn_low[0] - b_csn);
    end
    $display("abort_start_idle: start ignored");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++) tx_mem[0][i] = 8'($urandom);
    run_xfer("busy_start", 0, 2, 1'b0, 30);
    run_xfer("back_to_back", 0, 1, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    int b_rx, b_done;
    for (int i = 0; i < 32; i++) tx_mem[0][i] = 8'($urandom);
    miso_mode[0] = 1'b0;
    step;
    start_s[0] = 1'b1;
    length_s[0] = 6'd3;
    step;
    start_s[0] = 1'b0;
    repeat (50) step;
    b_rx = rx_cnt[0]; b_done = done_cnt[0];
    #2 reset_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({busy_s[u], done_s[u], rx_we_s[u], tx_addr_s[u], rx_addr_s[u], rx_data_s[u],
           sck_s[u], csn_s[u], mosi_s[u]} !== {3'b000, 5'd0, 5'd0, 8'd0, 3'b110}) begin
        errors++;
        $display("FAIL reset_mid u%0d: got busy=%b tx_addr=%0d rx_data=%02h sck=%b csn=%b mosi=%b",
                 u, busy_s[u], tx_addr_s[u], rx_data_s[u], sck_s[u], csn_s[u], mosi_s[u]);
      end
    end
    repeat (3) step;
    reset_n = 1'b1;
    repeat (200) step;
    checks++;
    if (done_cnt[0] != b_done || rx_cnt[0] != b_rx || csn_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_quiet: got dones=%0d rx=%0d csn=%b want 0/0/1",
               done_cnt[0] - b_done, rx_cnt[0] - b_rx, csn_s[0]);
    end
    $display("reset_mid: engine quiet after reset");
    run_xfer("after_reset", 0, 2, 1'b0, 0);
  endtask

  initial begin
    repeat (3) step;
    test_reset;
    reset_n = 1'b1;
    step;
    test_single_loopback;
    test_three_bytes;
    test_random;
    test_max_fast;
    test_zero_length;
    test_abort;
    test_abort_start_idle;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
